// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framing transmitter: start bit, data bits, optional even parity, stop bit(s).
// One word per valid/ready handshake; bit period set by a clock-enable cycle counter.
module serial_frame_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned MSB_FIRST    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_DONE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cyc, cyc_n;
    logic [BW-1:0]     bit_idx, bit_n;
    logic [WIDTH-1:0]  shreg, sh_n;
    logic              parity, par_n;
    logic              tx_n, busy_n, done_n;

    logic              wrap;
    logic              cur_bit;
    logic [WIDTH-1:0]  shifted;

    assign din_ready = (state == IDLE) & rst_n;
    assign wrap      = (cyc == CYC_LAST);
    assign cur_bit   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign shifted   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

    // State and output registers; reset also aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
            parity  <= par_n;
            tx      <= tx_n;
            busy    <= busy_n;
            tx_done <= done_n;
        end
    end

    // Next-state logic; tx is computed one cycle ahead so it only moves on bit boundaries.
    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bit_n   = bit_idx;
        sh_n    = shreg;
        par_n   = parity;
        tx_n    = tx;
        done_n  = 1'b0;

        if (state != IDLE) begin
            cyc_n = wrap ? '0 : cyc + CW'(1);
        end

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (din_valid && din_ready) begin
                    state_n = START;
                    sh_n    = din;
                    par_n   = ^din;
                    tx_n    = 1'b0;
                    cyc_n   = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (wrap) begin
                    state_n = DATA;
                    tx_n    = cur_bit;
                    sh_n    = shifted;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_idx == BIT_LAST) begin
                        bit_n = '0;
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = parity;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_idx + BW'(1);
                        tx_n  = cur_bit;
                        sh_n  = shifted;
                    end
                end
            end
            PARITY: begin
                if (wrap) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                // Registered pulse lands in the last cycle of the last stop bit.
                done_n = (bit_idx == STOP_LAST) && (cyc == CYC_DONE);
                if (wrap) begin
                    if (bit_idx == STOP_LAST) begin
                        state_n = IDLE;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: three parameterisations, scoreboard of per-cycle tx/tx_done.
module tb_serial_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] din0, din1, din2;
    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic tx;
        logic done;
    } exp_t;

    exp_t q[$];

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .MSB_FIRST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(v0), .din_ready(rdy0),
        .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1), .din_ready(rdy1),
        .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(0), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .din_valid(v2), .din_ready(rdy2),
        .tx(tx2), .busy(busy2), .tx_done(done2)
    );

    function automatic logic get_tx(input int s);
        case (s)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_done(input int s);
        case (s)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_ready(input int s);
        case (s)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int s, input logic [7:0] word, input logic valid);
        case (s)
            0: begin din0 = word; v0 = valid; end
            1: begin din1 = word; v1 = valid; end
            default: begin din2 = word; v2 = valid; end
        endcase
    endtask

    // Reference frame model: one queue entry per clk cycle after the handshake edge.
    task automatic build_expected(input int w, input int cpb, input int par, input int msb,
                                  input int stops, input logic [7:0] word);
        int   slots;
        logic p;
        logic b;
        exp_t e;
        p = 1'b0;
        for (int i = 0; i < w; i++) p = p ^ word[i];
        slots = 1 + w + par + stops;
        for (int s = 0; s < slots; s++) begin
            if (s == 0)             b = 1'b0;
            else if (s <= w)        b = (msb != 0) ? word[w - s] : word[s - 1];
            else if (s == w + 1 && par != 0) b = p;
            else                    b = 1'b1;
            for (int c = 0; c < cpb; c++) begin
                e.tx   = b;
                e.done = (s == slots - 1) && (c == cpb - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_cycles(input int s, input int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            e = q.pop_front();
            chk($sformatf("tx u%0d c%0d", s, k), get_tx(s), e.tx);
            chk($sformatf("tx_done u%0d c%0d", s, k), get_done(s), e.done);
            chk($sformatf("busy u%0d c%0d", s, k), get_busy(s), 1'b1);
            chk($sformatf("din_ready u%0d c%0d", s, k), get_ready(s), 1'b0);
        end
    endtask

    task automatic send(input int s, input logic [7:0] word);
        @(negedge clk);
        chk($sformatf("ready_before_send u%0d", s), get_ready(s), 1'b1);
        set_in(s, word, 1'b1);
        @(posedge clk);
        #1;
        set_in(s, 8'h00, 1'b0);
    endtask

    task automatic check_idle(input int s, input string tag);
        @(negedge clk);
        chk($sformatf("%s ready u%0d", tag, s), get_ready(s), 1'b1);
        chk($sformatf("%s busy u%0d", tag, s), get_busy(s), 1'b0);
        chk($sformatf("%s tx u%0d", tag, s), get_tx(s), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);
        set_in(2, 8'h00, 1'b0);

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst ready gated", rdy0, 1'b0);
        chk("rst tx", tx0, 1'b1);
        chk("rst busy", busy0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("post_rst ready u%0d", s), get_ready(s), 1'b1);
            chk($sformatf("post_rst tx u%0d", s), get_tx(s), 1'b1);
            chk($sformatf("post_rst busy u%0d", s), get_busy(s), 1'b0);
            chk($sformatf("post_rst done u%0d", s), get_done(s), 1'b0);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk($sformatf("idle tx c%0d", k), tx0, 1'b1);
        end

        // Single frame, LSB first, 0xA5
        build_expected(8, 4, 0, 0, 1, 8'hA5);
        send(0, 8'hA5);
        check_cycles(0, 40);
        check_idle(0, "a5_end");

        // Even parity: 0x07 -> parity 1, 0xA5 -> parity 0
        build_expected(8, 4, 1, 0, 1, 8'h07);
        send(1, 8'h07);
        check_cycles(1, 44);
        check_idle(1, "par07_end");
        build_expected(8, 4, 1, 0, 1, 8'hA5);
        send(1, 8'hA5);
        check_cycles(1, 44);
        check_idle(1, "para5_end");

        // MSB first, two stop bits, 0x81
        build_expected(8, 4, 0, 1, 2, 8'h81);
        send(2, 8'h81);
        check_cycles(2, 44);
        check_idle(2, "msb81_end");

        // Back-to-back with din_valid held high across the first frame
        build_expected(8, 4, 0, 0, 1, 8'h55);
        @(negedge clk);
        set_in(0, 8'h55, 1'b1);
        @(posedge clk);
        #1;
        din0 = 8'h0F;
        check_cycles(0, 40);
        @(negedge clk);
        chk("b2b gap ready", rdy0, 1'b1);
        chk("b2b gap tx", tx0, 1'b1);
        chk("b2b gap busy", busy0, 1'b0);
        build_expected(8, 4, 0, 0, 1, 8'h0F);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        check_cycles(0, 40);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("b2b after tx c%0d", k), tx0, 1'b1);
            chk($sformatf("b2b after busy c%0d", k), busy0, 1'b0);
        end

        // Reset during data bit 3 of 0xFF
        build_expected(8, 4, 0, 0, 1, 8'hFF);
        send(0, 8'hFF);
        check_cycles(0, 18);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst tx", tx0, 1'b1);
        chk("midrst busy", busy0, 1'b0);
        chk("midrst done", done0, 1'b0);
        chk("midrst ready gated", rdy0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("after_rst ready c%0d", k), rdy0, 1'b1);
            chk($sformatf("after_rst done c%0d", k), done0, 1'b0);
            chk($sformatf("after_rst tx c%0d", k), tx0, 1'b1);
        end
        build_expected(8, 4, 0, 0, 1, 8'h3C);
        send(0, 8'h3C);
        check_cycles(0, 40);
        check_idle(0, "3c_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
